// File: rtl/formula_2_shared_pkg.sv
// rtl/formula_2_shared_pkg.sv - shared types and constants for the time-shared isqrt formula block
package formula_2_shared_pkg;

    localparam int DATA_W    = 32;
    localparam int DEPTH_DEF = 16;
    // One item re-enters the isqrt pipe every P cycles, so at most P items can be in flight.
    localparam int P         = DEPTH_DEF + 1;

    typedef enum logic [1:0] {
        PASS_C   = 2'd0,
        PASS_BC  = 2'd1,
        PASS_ABC = 2'd2
    } pass_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        pass_t             tag;
    } sideband_t;

endpackage

// File: rtl/formula_2_shared_isqrt_if.sv
// rtl/formula_2_shared_isqrt_if.sv - argument/result bundle for formula_2_shared_isqrt
interface formula_2_shared_isqrt_if #(
    parameter int WIDTH = 32
);
    logic             arg_vld;
    logic             arg_rdy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             res_vld;
    logic [WIDTH-1:0] res;
    logic             busy;

    modport master (
        output arg_vld, a, b, c,
        input  arg_rdy, res_vld, res, busy
    );

    modport slave (
        input  arg_vld, a, b, c,
        output arg_rdy, res_vld, res, busy
    );
endinterface

// File: rtl/isqrt.sv
// rtl/isqrt.sv - pipelined integer square root, floor(sqrt(x)), fixed latency n_pipe_stages
module isqrt #(
    parameter int WIDTH         = 32,
    parameter int n_pipe_stages = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_vld,
    input  logic [WIDTH-1:0] x,
    output logic             y_vld,
    output logic [WIDTH-1:0] y
);
    localparam int ITER = WIDTH / 2;
    localparam int IPS  = (ITER + n_pipe_stages - 1) / n_pipe_stages;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] root;
    } sq_t;

    // One radix-4 digit of the restoring square-root recurrence.
    function automatic sq_t sq_step(sq_t s);
        sq_t              o;
        logic [WIDTH-1:0] trial;
        o.rem = {s.rem[WIDTH-3:0], s.x[WIDTH-1:WIDTH-2]};
        o.x   = {s.x[WIDTH-3:0], 2'b00};
        trial = {s.root[WIDTH-3:0], 2'b01};
        if (o.rem >= trial) begin
            o.rem  = o.rem - trial;
            o.root = {s.root[WIDTH-2:0], 1'b1};
        end else begin
            o.root = {s.root[WIDTH-2:0], 1'b0};
        end
        return o;
    endfunction

    sq_t                    q   [n_pipe_stages];
    sq_t                    nxt [n_pipe_stages];
    logic [n_pipe_stages-1:0] vld_q;

    always_comb begin
        sq_t cur;
        cur = '0;
        for (int s = 0; s < n_pipe_stages; s++) begin
            if (s == 0) begin
                cur.x    = x;
                cur.rem  = '0;
                cur.root = '0;
            end else begin
                cur = q[s-1];
            end
            for (int i = 0; i < IPS; i++) begin
                if (s * IPS + i < ITER) begin
                    cur = sq_step(cur);
                end
            end
            nxt[s] = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= x_vld;
            for (int s = 1; s < n_pipe_stages; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    // Data stages only toggle when a valid item moves through them.
    always_ff @(posedge clk) begin
        if (x_vld) begin
            q[0] <= nxt[0];
        end
        for (int s = 1; s < n_pipe_stages; s++) begin
            if (vld_q[s-1]) begin
                q[s] <= nxt[s];
            end
        end
    end

    assign y_vld = vld_q[n_pipe_stages-1];
    assign y     = q[n_pipe_stages-1].root;

endmodule

// File: rtl/shift_register_with_valid.sv
// rtl/shift_register_with_valid.sv - fixed-depth delay line with per-stage valid and occupancy flag
module shift_register_with_valid #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [width-1:0] in_data,
    output logic             out_vld,
    output logic [width-1:0] out_data,
    output logic             any_vld
);
    logic [width-1:0] data_q [depth];
    logic [depth-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int s = 1; s < depth; s++) begin
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_vld) begin
            data_q[0] <= in_data;
        end
        for (int s = 1; s < depth; s++) begin
            if (vld_q[s-1]) begin
                data_q[s] <= data_q[s-1];
            end
        end
    end

    assign out_vld  = vld_q[depth-1];
    assign out_data = data_q[depth-1];
    assign any_vld  = |vld_q;

endmodule

// File: rtl/formula_2_shared_isqrt.sv
// rtl/formula_2_shared_isqrt.sv - isqrt(a + isqrt(b + isqrt(c))) on one time-shared isqrt pipeline
module formula_2_shared_isqrt
    import formula_2_shared_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    formula_2_shared_isqrt_if.slave       io
);
    logic             recirc_vld;
    logic [WIDTH-1:0] recirc_sum;
    sideband_t        recirc_sb;

    logic             accept;
    logic             x_vld;
    logic [WIDTH-1:0] x;
    logic             y_vld;
    logic [WIDTH-1:0] y;
    sideband_t        sb_in;
    sideband_t        sb_out;
    logic             sb_vld;
    logic             sb_any;
    logic             done;

    // A recirculating item always wins the issue slot, so new arguments wait.
    assign io.arg_rdy = !rst && !recirc_vld;
    assign accept     = io.arg_vld && io.arg_rdy;
    assign x_vld      = !rst && (recirc_vld || accept);
    assign x          = recirc_vld ? recirc_sum : io.c;

    always_comb begin
        sb_in = recirc_sb;
        if (!recirc_vld) begin
            sb_in.a   = io.a;
            sb_in.b   = io.b;
            sb_in.tag = PASS_C;
        end
    end

    isqrt #(
        .WIDTH         (WIDTH),
        .n_pipe_stages (DEPTH)
    ) u_isqrt (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x_vld),
        .x     (x),
        .y_vld (y_vld),
        .y     (y)
    );

    shift_register_with_valid #(
        .width ($bits(sideband_t)),
        .depth (DEPTH)
    ) u_sideband (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (x_vld),
        .in_data  (sb_in),
        .out_vld  (sb_vld),
        .out_data (sb_out),
        .any_vld  (sb_any)
    );

    assign done = y_vld && sb_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            recirc_vld <= 1'b0;
        end else begin
            recirc_vld <= done && (sb_out.tag == PASS_C || sb_out.tag == PASS_BC);
        end
    end

    always_ff @(posedge clk) begin
        if (done) begin
            case (sb_out.tag)
                PASS_C: begin
                    recirc_sum    <= y + sb_out.b;
                    recirc_sb.a   <= sb_out.a;
                    recirc_sb.b   <= sb_out.b;
                    recirc_sb.tag <= PASS_BC;
                end
                PASS_BC: begin
                    recirc_sum    <= y + sb_out.a;
                    recirc_sb.a   <= sb_out.a;
                    recirc_sb.b   <= sb_out.b;
                    recirc_sb.tag <= PASS_ABC;
                end
                default: ;
            endcase
        end
    end

    assign io.res_vld = !rst && done && (sb_out.tag == PASS_ABC);
    assign io.res     = y;
    assign io.busy    = !rst && (recirc_vld || sb_any);

endmodule

// File: tb/tb_formula_2_shared_isqrt.sv
// tb/tb_formula_2_shared_isqrt.sv - randomized self-checking bench for formula_2_shared_isqrt
module tb_formula_2_shared_isqrt;

    localparam int PP  = 17;
    localparam int LAT = 50;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    formula_2_shared_isqrt_if #(.WIDTH(32)) bus ();

    formula_2_shared_isqrt #(.WIDTH(32), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] v;
    } exp_t;

    int   acc_q[$];
    exp_t exp_q[$];

    function automatic logic [31:0] isqrt_ref(logic [31:0] v);
        longint unsigned r, cand, vv;
        r  = 0;
        vv = {32'd0, v};
        for (int bt = 15; bt >= 0; bt--) begin
            cand = r | (64'd1 << bt);
            if (cand * cand <= vv) r = cand;
        end
        return r[31:0];
    endfunction

    function automatic logic [31:0] f_ref(logic [31:0] a, logic [31:0] b, logic [31:0] c);
        logic [31:0] s;
        s = b + isqrt_ref(c);
        s = a + isqrt_ref(s);
        return isqrt_ref(s);
    endfunction

    function automatic bit was_acc(int t);
        foreach (acc_q[i]) if (acc_q[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    // Drives one cycle and returns what the reference model expects to see in it.
    task automatic clk_step(input bit vld, input logic [31:0] ia, ib, ic, input bit r,
                            output bit m_rdy, m_busy, m_issue, m_rvld,
                            output logic [31:0] m_res, output bit acc);
        int now;
        @(posedge clk);
        #1;
        rst         = r;
        bus.arg_vld = vld;
        bus.a       = ia;
        bus.b       = ib;
        bus.c       = ic;
        now     = cyc;
        m_rdy   = 0;
        m_busy  = 0;
        m_issue = 0;
        m_rvld  = 0;
        m_res   = '0;
        acc     = 0;
        if (r) begin
            acc_q.delete();
            exp_q.delete();
        end else begin
            while (acc_q.size() > 0 && acc_q[0] < now - 60) void'(acc_q.pop_front());
            m_rdy = !was_acc(now - PP) && !was_acc(now - 2 * PP);
            acc   = vld && m_rdy;
            foreach (acc_q[i]) if (acc_q[i] >= now - LAT && acc_q[i] <= now - 1) m_busy = 1;
            m_issue = acc || !m_rdy;
            if (exp_q.size() > 0 && exp_q[0].due == now) begin
                m_rvld = 1;
                m_res  = exp_q[0].v;
                void'(exp_q.pop_front());
            end
            if (acc) begin
                acc_q.push_back(now);
                exp_q.push_back('{due: now + LAT, v: f_ref(ia, ib, ic)});
            end
        end
        #4;
    endtask

    task automatic test_reset();
        bit r, bz, is, rv, acc;
        logic [31:0] rr;
        for (int k = 0; k < 3; k++) begin
            clk_step(1, 32'd9, 32'd9, 32'd9, 1, r, bz, is, rv, rr, acc);
            checks++;
            if (bus.arg_rdy !== 1'b0 || bus.res_vld !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: arg_rdy=%b res_vld=%b busy=%b required 0 0 0",
                         bus.arg_rdy, bus.res_vld, bus.busy);
            end
        end
        clk_step(0, 0, 0, 0, 0, r, bz, is, rv, rr, acc);
        checks++;
        if (bus.arg_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: arg_rdy=%b required 1", bus.arg_rdy);
        end
    endtask

    task automatic test_single(input logic [31:0] ia, ib, ic, exp_res);
        bit r, bz, is, rv, acc;
        logic [31:0] rr;
        clk_step(1, ia, ib, ic, 0, r, bz, is, rv, rr, acc);
        checks++;
        if (bus.arg_rdy !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: arg_rdy=%b required 1", bus.arg_rdy);
        end
        for (int k = 1; k <= 55; k++) begin
            clk_step(0, 0, 0, 0, 0, r, bz, is, rv, rr, acc);
            checks++;
            if (bus.res_vld !== (k == LAT) || bus.busy !== (k <= LAT)) begin
                errors++;
                $display("FAIL single_timing k=%0d: res_vld=%b busy=%b required %b %b",
                         k, bus.res_vld, bus.busy, k == LAT, k <= LAT);
            end
            if (k == LAT) begin
                checks++;
                if (bus.res !== exp_res) begin
                    errors++;
                    $display("FAIL single_res a=%0h b=%0h c=%0h: res=%0h required %0h",
                             ia, ib, ic, bus.res, exp_res);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit r, bz, is, rv, acc;
        logic [31:0] rr;
        int idx = 0;
        int nres = 0;
        for (int k = 0; k <= 70; k++) begin
            clk_step(k <= LAT, idx * 3 + 1, idx * 7, idx * idx * 11, 0, r, bz, is, rv, rr, acc);
            if (acc) idx++;
            checks++;
            if (bus.arg_rdy !== (k <= 16 || k >= 51) || bus.arg_rdy !== r) begin
                errors++;
                $display("FAIL b2b_rdy k=%0d: arg_rdy=%b required %b", k, bus.arg_rdy, r);
            end
            checks++;
            if (bus.res_vld !== rv || (rv && bus.res !== rr)) begin
                errors++;
                $display("FAIL b2b_res k=%0d: res_vld=%b res=%0h required %b %0h",
                         k, bus.res_vld, bus.res, rv, rr);
            end
            if (bus.res_vld === 1'b1 && k >= 50 && k <= 66) nres++;
        end
        checks++;
        if (nres != 17) begin
            errors++;
            $display("FAIL b2b_count: results=%0d required 17", nres);
        end
    endtask

    task automatic test_reset_mid();
        bit r, bz, is, rv, acc;
        logic [31:0] rr;
        logic [31:0] exp_new;
        exp_new = f_ref(32'd1000, 32'd77, 32'd123456);
        for (int k = 0; k <= 75; k++) begin
            if (k < 5)
                clk_step(1, k * 5 + 2, k + 9, k * 100 + 3, 0, r, bz, is, rv, rr, acc);
            else if (k == 20)
                clk_step(0, 0, 0, 0, 1, r, bz, is, rv, rr, acc);
            else if (k == 21)
                clk_step(1, 32'd1000, 32'd77, 32'd123456, 0, r, bz, is, rv, rr, acc);
            else
                clk_step(0, 0, 0, 0, 0, r, bz, is, rv, rr, acc);
            if (k == 21) begin
                checks++;
                if (bus.busy !== 1'b0 || bus.arg_rdy !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_release: busy=%b arg_rdy=%b required 0 1",
                             bus.busy, bus.arg_rdy);
                end
            end
            checks++;
            if (bus.res_vld !== (k == 71)) begin
                errors++;
                $display("FAIL rstmid_res_vld k=%0d: res_vld=%b required %b", k, bus.res_vld, k == 71);
            end
            if (k == 71) begin
                checks++;
                if (bus.res !== exp_new) begin
                    errors++;
                    $display("FAIL rstmid_res: res=%0h required %0h", bus.res, exp_new);
                end
            end
        end
    endtask

    task automatic test_random();
        bit r, bz, is, rv, acc;
        logic [31:0] rr, ha, hb, hc;
        bit hv = 0;
        int nacc = 0;
        int nres = 0;
        for (int k = 0; k < 10000 + 60; k++) begin
            if (!hv && k < 10000) begin
                hv = ($urandom_range(99) < 30);
                ha = $urandom >> $urandom_range(31);
                hb = $urandom >> $urandom_range(31);
                hc = $urandom >> $urandom_range(31);
            end
            clk_step(hv, ha, hb, hc, 0, r, bz, is, rv, rr, acc);
            if (acc) begin
                hv = 0;
                nacc++;
            end
            if (bus.res_vld === 1'b1) nres++;
            checks++;
            if (bus.arg_rdy !== r || bus.busy !== bz || dut.x_vld !== is) begin
                errors++;
                if (errors < 40)
                    $display("FAIL rand_ctrl k=%0d: rdy=%b busy=%b issue=%b required %b %b %b",
                             k, bus.arg_rdy, bus.busy, dut.x_vld, r, bz, is);
            end
            checks++;
            if (bus.res_vld !== rv || (rv && bus.res !== rr)) begin
                errors++;
                if (errors < 40)
                    $display("FAIL rand_res k=%0d: res_vld=%b res=%0h required %b %0h",
                             k, bus.res_vld, bus.res, rv, rr);
            end
        end
        checks++;
        if (nres != nacc) begin
            errors++;
            $display("FAIL rand_count: results=%0d required %0d", nres, nacc);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.arg_vld = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.c       = '0;
        test_reset();
        test_single(32'd7, 32'd5, 32'd16, 32'd3);
        test_single(32'd62, 32'd14, 32'd4, 32'd8);
        test_single(32'd0, 32'd0, 32'd0, 32'd0);
        test_single(32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
